// File: rtl/dvp_capture_pkg.sv
// Shared types and constants for the DVP pixel capture front-end.
// The optional DVP_TESTPATTERN_EN build uses rgb565() to synthesise pattern pixels.
package dvp_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    FRAME   = 2'd2,
    DROP    = 2'd3
  } state_t;

  localparam int PIX_W   = 16;
  localparam int ENTRY_W = 18;

  // FIFO entry layout: {eop, sop, pixel}
  localparam int ENTRY_SOP_BIT = 16;
  localparam int ENTRY_EOP_BIT = 17;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;

  function automatic logic [PIX_W-1:0] rgb565(input logic [4:0] r,
                                              input logic [5:0] g,
                                              input logic [4:0] b);
    logic [PIX_W-1:0] p;
    p = '0;
    p[R_MSB:R_LSB] = r;
    p[G_MSB:G_LSB] = g;
    p[B_MSB:B_LSB] = b;
    return p;
  endfunction

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic sop,
                                                    input logic eop,
                                                    input logic [PIX_W-1:0] pix);
    return {eop, sop, pix};
  endfunction

endpackage

// File: rtl/dvp_pixel_fifo.sv
// Synchronous first-word-fall-through FIFO; a push while full is accepted
// only when a pop happens in the same cycle.
module dvp_pixel_fifo
  import dvp_capture_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = ENTRY_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign wr_en    = push && (!full || pop);
  assign rd_en    = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dvp_pixel_capture.sv
// DVP camera capture: oversampled pclk/href/vsync, RGB565 byte-pair assembly,
// framed FWFT output stream. Optional macro DVP_TESTPATTERN_EN adds test_mode.
module dvp_pixel_capture
  import dvp_capture_pkg::*;
#(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dvp_pclk,
  input  logic [7:0]       dvp_data,
  input  logic             dvp_href,
  input  logic             dvp_vsync,
  input  logic             enable,
`ifdef DVP_TESTPATTERN_EN
  input  logic             test_mode,
`endif
  output logic [PIX_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sop,
  output logic             out_eop,
  output logic             frame_done,
  output logic             status_overflow,
  output logic             status_frame_err
);

  localparam int XW = ($clog2(H_ACTIVE + 2) > 8) ? $clog2(H_ACTIVE + 2) : 8;
  localparam int YW = ($clog2(V_ACTIVE + 2) > 8) ? $clog2(V_ACTIVE + 2) : 8;
  localparam logic [XW-1:0] X_END  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_END  = YW'(V_ACTIVE);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic pclk_p0, pclk_p1, pclk_p2;
  logic href_p0, href_p1, href_p2;
  logic vsync_p0, vsync_p1, vsync_p2;
  logic [7:0] data_p0, data_p1;

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          phase;
  logic [7:0]    hi_byte;

  logic pclk_rise, href_rise, href_fall, vs_rise, vs_fall;
  logic phase_eff, pix_fire, in_window, push, pop, ovf, push_ok;
  logic is_sop, is_eop;
  logic fifo_full, fifo_empty;
  logic [PIX_W-1:0]   pixel;
  logic [ENTRY_W-1:0] push_entry, rd_entry;

  // Stage p0/p1: two-flop synchroniser; p2: previous sample for edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      {pclk_p0, pclk_p1, pclk_p2}    <= '0;
      {href_p0, href_p1, href_p2}    <= '0;
      {vsync_p0, vsync_p1, vsync_p2} <= '0;
    end else begin
      {pclk_p0, pclk_p1, pclk_p2}    <= {dvp_pclk, pclk_p0, pclk_p1};
      {href_p0, href_p1, href_p2}    <= {dvp_href, href_p0, href_p1};
      {vsync_p0, vsync_p1, vsync_p2} <= {dvp_vsync, vsync_p0, vsync_p1};
    end
  end

  always_ff @(posedge clk) begin
    data_p0 <= dvp_data;
    data_p1 <= data_p0;
  end

  assign pclk_rise = pclk_p1 & ~pclk_p2;
  assign href_rise = href_p1 & ~href_p2;
  assign href_fall = ~href_p1 & href_p2;
  assign vs_rise   = vsync_p1 & ~vsync_p2;
  assign vs_fall   = ~vsync_p1 & vsync_p2;

  // A line start coinciding with a byte strobe must still see phase 0
  assign phase_eff = phase & ~href_rise;
  assign pix_fire  = (state == FRAME) && pclk_rise && href_p1 && phase_eff;
  assign in_window = (x < X_END) && (y < Y_END);
  assign push      = pix_fire && in_window;
  assign pop       = out_valid && out_ready;
  assign ovf       = push && fifo_full && !pop;
  assign push_ok   = push && !ovf;
  assign is_sop    = (x == '0) && (y == '0);
  assign is_eop    = (x == X_LAST) && (y == Y_LAST);

`ifdef DVP_TESTPATTERN_EN
  assign pixel = test_mode ? rgb565(x[7:3], y[7:2], x[7:3]) : {hi_byte, data_p1};
`else
  assign pixel = {hi_byte, data_p1};
`endif

  assign push_entry = pack_entry(is_sop, is_eop, pixel);

  always_ff @(posedge clk) begin
    if (pclk_rise && href_p1 && !phase_eff) hi_byte <= data_p1;
  end

  // Stage p3: frame state, counters, flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      x                <= '0;
      y                <= '0;
      phase            <= 1'b0;
      frame_done       <= 1'b0;
      status_overflow  <= 1'b0;
      status_frame_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state <= WAIT_VS;
          end else begin
            status_overflow  <= 1'b0;
            status_frame_err <= 1'b0;
          end
        end
        WAIT_VS: begin
          if (vs_fall) begin
            state <= FRAME;
            x     <= '0;
            y     <= '0;
            phase <= 1'b0;
          end
        end
        FRAME: begin
          if (href_rise) phase <= 1'b0;
          if (pclk_rise && href_p1) begin
            if (!phase_eff) begin
              phase <= 1'b1;
            end else begin
              phase <= 1'b0;
              if (x <= X_END) x <= x + 1'b1;
            end
          end
          // Counters saturate just past the limit so long lines stay flagged
          if (href_fall) begin
            if (x != X_END) status_frame_err <= 1'b1;
            if (y <= Y_END) y <= y + 1'b1;
            x     <= '0;
            phase <= 1'b0;
          end
          if (ovf) begin
            status_overflow <= 1'b1;
            state           <= DROP;
          end else if (push_ok && is_eop) begin
            frame_done <= 1'b1;
            state      <= enable ? WAIT_VS : IDLE;
          end else if (vs_rise) begin
            if (y < Y_END) status_frame_err <= 1'b1;
            state <= enable ? WAIT_VS : IDLE;
          end
        end
        DROP: begin
          if (vs_rise) state <= WAIT_VS;
        end
        default: state <= IDLE;
      endcase
    end
  end

  dvp_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .full      (fifo_full),
    .pop       (pop),
    .pop_data  (rd_entry),
    .empty     (fifo_empty)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = out_valid ? rd_entry[PIX_W-1:0] : '0;
  assign out_sop   = out_valid & rd_entry[ENTRY_SOP_BIT];
  assign out_eop   = out_valid & rd_entry[ENTRY_EOP_BIT];

endmodule

// File: doc/dvp_pixel_capture.md
Name: dvp_pixel_capture

Overview:
Camera front-end feeding the frame-buffer write path of the DVP capture system. It oversamples the DVP bus (pclk/href/vsync/data[7:0]) in the system clock domain. It assembles byte pairs into RGB565 pixels and emits them on a valid/ready stream with sop/eop framing. It buffers pixels in a small FIFO and reports overflow, frame errors and frame completion.

Parameters:
H_ACTIVE, 640, pixels per line (count of 16-bit pixels)
V_ACTIVE, 480, lines per frame
FIFO_DEPTH, 16, output FIFO entries; power of two, minimum 4

Ports:
clk  in  1  system clock; must be at least 3x dvp_pclk
reset  in  1  synchronous, active-high
dvp_pclk  in  1  camera pixel clock, asynchronous, sampled as data
dvp_data  in  8  camera byte bus
dvp_href  in  1  line valid, active high
dvp_vsync  in  1  frame sync, active high during blanking
enable  in  1  capture enable
out_data  out  16  RGB565 pixel; first byte is [15:8]
out_valid  out  1  pixel available
out_ready  in  1  downstream accept
out_sop  out  1  first pixel of frame (x=0, y=0)
out_eop  out  1  last pixel of frame (x=H_ACTIVE-1, y=V_ACTIVE-1)
frame_done  out  1  one-cycle pulse when the eop pixel is pushed into the FIFO
status_overflow  out  1  sticky; FIFO full on push
status_frame_err  out  1  sticky; line length or line count mismatch

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Port names are clk and reset.
- Reset values: all outputs 0, FIFO empty, state IDLE, counters 0, byte phase 0.
- Input sync: 2-flop synchroniser on pclk, href, vsync and data[7:0], plus a third stage for edge detect.
- A pclk rise is prev=0 and cur=1 on the synchronised pclk. href, vsync and data are taken from the stage aligned with cur.
- States: IDLE, WAIT_VS, FRAME, DROP.
  - IDLE -> WAIT_VS when enable=1.
  - WAIT_VS -> FRAME on a vsync falling edge. Clears x, y and byte phase.
  - FRAME -> WAIT_VS after the eop pixel is pushed, or on a vsync rising edge. If enable=0 at that point, go to IDLE instead.
  - FRAME -> DROP on overflow.
  - DROP -> WAIT_VS on a vsync rising edge.
- enable is sampled only in IDLE and at frame end. Deasserting it mid-frame lets the current frame complete.
- Pixel assembly: on a pclk rise with href=1, byte phase 0 latches the high byte. Byte phase 1 forms the pixel and pushes it into the FIFO, then x increments.
- Byte phase resets to 0 on every href rising edge. A trailing odd byte is discarded.
- Line end (href falling): if x != H_ACTIVE, set status_frame_err. Then y increments and x clears.
- Pixels with x >= H_ACTIVE or y >= V_ACTIVE are not pushed.
- A vsync rise while in FRAME with y < V_ACTIVE sets status_frame_err. No eop is emitted for that frame.
- Sideband: sop and eop are stored in the FIFO alongside the 16-bit data (18-bit entries).
- Overflow: a push while the FIFO is full sets status_overflow and drops the pixel. The state machine enters DROP, and the rest of the frame is discarded. The next frame starts normally with sop.
- Sticky flags clear when in IDLE with enable=0. reset also clears them.
- Output handshake: first-word-fall-through. out_* are valid while FIFO non-empty. Pop when out_valid & out_ready. out_data is stable while out_valid=1 and out_ready=0.
- A simultaneous push and pop when full is legal: the push succeeds and no overflow is raised.
- Latency: out_valid rises 1 cycle after the push into an empty FIFO. The push occurs 3 cycles after pclk rises at the pins.

Optional Feature:
Macro DVP_TESTPATTERN_EN. When defined, it adds input port test_mode (1 bit).
- With test_mode=1, each pushed pixel is replaced by {x[7:3], y[7:2], x[7:3]}.
- All camera timing, counting and framing are unchanged.
When the macro is undefined, the port is absent and data always comes from the camera.

Decomposition:
Package dvp_capture_pkg holds:
- state enum (IDLE, WAIT_VS, FRAME, DROP)
- PIX_W=16 and FIFO entry width 18
- RGB565 field positions
Sub-module dvp_pixel_fifo: synchronous FWFT FIFO with parameter depth, ports push/full/pop/empty.

Test Plan:
- H_ACTIVE=4, V_ACTIVE=2, clk:pclk=4:1, out_ready=1, bytes 0x01..0x10 -> pixels 0x0102,0x0304,…,0x0F10. sop on 0x0102, eop on 0x0F10, one frame_done pulse, no flags.
- out_ready=0 for the whole frame, FIFO_DEPTH=4 -> 4 pixels held, status_overflow=1 at the 5th push. Following frame begins with sop, values intact.
- Line of 3 pixels plus an odd byte -> status_frame_err=1, odd byte dropped, y still advances.
- vsync rises after 1 of 2 lines -> status_frame_err=1, no eop. Next frame sop at x=0,y=0.
- enable drops mid-frame -> frame completes with eop, then IDLE, flags cleared. No pixels output after that.
- With DVP_TESTPATTERN_EN and test_mode=1, pixel x=8,y=4 -> out_data 0x0821.
